// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches 16-bit instructions from a synchronous program ROM,
// decodes them and drives the alu control inputs (opcode, accumulator CE,
// register-file write select, operand-mux select). Conditional jumps test
// the accumulator value read back from the alu.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for i_start, o_busy low
// FETCH  | o_prog_addr presents PC to the ROM
// WAIT   | ROM read latency
// DECODE | instruction register loads i_prog_data, pulses set up
// EXEC   | CE pulses active, PC advances / jumps, HALT returns to IDLE

package alu_pkg;
  typedef logic [3:0] operation;
  localparam operation OP_PASS = 4'd0;
  localparam operation OP_ADD  = 4'd1;
  localparam operation OP_SUB  = 4'd2;
  localparam operation OP_AND  = 4'd3;
  localparam operation OP_OR   = 4'd4;
  localparam operation OP_XOR  = 4'd5;
endpackage

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int PROG_AW = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic [PROG_AW-1:0] o_prog_addr,
  input  logic [15:0]        i_prog_data,
  input  logic [7:0]         i_acumulator,
  output operation           o_operation_code,
  output logic               o_acumulator_ce,
  output logic [2:0]         o_register_file_ce,
  output logic [3:0]         o_register_file_mux_addr,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  localparam logic [1:0] C_EXEC  = 2'b00;
  localparam logic [1:0] C_STORE = 2'b01;
  localparam logic [1:0] C_JUMPZ = 2'b10;
  localparam logic [1:0] C_HALT  = 2'b11;

  state_t             state, state_nxt;
  logic [PROG_AW-1:0] pc, pc_nxt;
  logic [15:0]        ir, ir_nxt;
  logic [PROG_AW-1:0] jump_target;

  logic [PROG_AW-1:0] addr_nxt;
  operation           op_nxt;
  logic               acu_ce_nxt;
  logic [2:0]         rf_ce_nxt;
  logic [3:0]         mux_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  // op/mux fields are consumed straight from the ROM in DECODE, so the
  // IR copies of them are only kept for visibility.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[13:8];

  assign jump_target = PROG_AW'(ir[7:0]);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: fixed four-cycle instruction loop, HALT exits to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (ir[15:14] == C_HALT) ? S_IDLE : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; pulses are prepared in DECODE so the
  // registered outputs are valid exactly during the EXEC cycle.
  always_comb begin
    pc_nxt     = pc;
    ir_nxt     = ir;
    addr_nxt   = o_prog_addr;
    op_nxt     = o_operation_code;
    mux_nxt    = o_register_file_mux_addr;
    acu_ce_nxt = 1'b0;
    rf_ce_nxt  = 3'd0;
    busy_nxt   = o_busy;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          pc_nxt   = '0;
          addr_nxt = '0;
          busy_nxt = 1'b1;
        end
      end
      S_DECODE: begin
        ir_nxt = i_prog_data;
        case (i_prog_data[15:14])
          C_EXEC: begin
            op_nxt     = operation'(i_prog_data[13:10]);
            mux_nxt    = i_prog_data[9:6];
            acu_ce_nxt = 1'b1;
          end
          C_STORE: rf_ce_nxt = i_prog_data[2:0];
          C_HALT: begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        case (ir[15:14])
          C_JUMPZ: pc_nxt = (i_acumulator == 8'd0) ? jump_target : pc + PROG_AW'(1);
          C_HALT:  pc_nxt = '0;
          default: pc_nxt = pc + PROG_AW'(1);
        endcase
        if (ir[15:14] != C_HALT) addr_nxt = pc_nxt;
      end
      default: ;
    endcase
  end

  // Registered outputs, PC and IR.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc                       <= '0;
      ir                       <= '0;
      o_prog_addr              <= '0;
      o_operation_code         <= operation'(0);
      o_acumulator_ce          <= 1'b0;
      o_register_file_ce       <= 3'd0;
      o_register_file_mux_addr <= 4'd0;
      o_busy                   <= 1'b0;
      o_done                   <= 1'b0;
    end else begin
      pc                       <= pc_nxt;
      ir                       <= ir_nxt;
      o_prog_addr              <= addr_nxt;
      o_operation_code         <= op_nxt;
      o_acumulator_ce          <= acu_ce_nxt;
      o_register_file_ce       <= rf_ce_nxt;
      o_register_file_mux_addr <= mux_nxt;
      o_busy                   <= busy_nxt;
      o_done                   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: ROM model plus per-cycle trace capture.
// Trace index k is the k-th cycle after the edge that accepts i_start
// (k=1 FETCH, k=4 first EXEC).
module tb_alu_sequencer;
  import alu_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic [7:0] o_prog_addr;
  logic [15:0] i_prog_data;
  logic [7:0] i_acumulator;
  operation   o_operation_code;
  logic       o_acumulator_ce;
  logic [2:0] o_register_file_ce;
  logic [3:0] o_register_file_mux_addr;
  logic       o_busy;
  logic       o_done;

  always #5 i_clk = ~i_clk;

  alu_sequencer #(.PROG_AW(8)) dut (
    .i_clk                   (i_clk),
    .i_rst                   (i_rst),
    .i_start                 (i_start),
    .o_prog_addr             (o_prog_addr),
    .i_prog_data             (i_prog_data),
    .i_acumulator            (i_acumulator),
    .o_operation_code        (o_operation_code),
    .o_acumulator_ce         (o_acumulator_ce),
    .o_register_file_ce      (o_register_file_ce),
    .o_register_file_mux_addr(o_register_file_mux_addr),
    .o_busy                  (o_busy),
    .o_done                  (o_done)
  );

  logic [15:0] rom [256];
  always @(posedge i_clk) i_prog_data <= rom[o_prog_addr];

  localparam logic [15:0] I_HALT = 16'hC000;
  localparam logic [15:0] I_NOP  = 16'h4000;

  int checks = 0;
  int errors = 0;

  logic       tr_acu  [64];
  logic [2:0] tr_rf   [64];
  logic       tr_done [64];
  logic       tr_busy [64];
  logic [7:0] tr_addr [64];
  logic [3:0] tr_op   [64];
  logic [3:0] tr_mux  [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 256; i++) rom[i] = w;
  endtask

  task automatic run_prog(input int n, input int sw_idx, input logic [7:0] sw_acc,
                          input int start_idx, input int rst_idx);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tr_acu[k]  = o_acumulator_ce;
      tr_rf[k]   = o_register_file_ce;
      tr_done[k] = o_done;
      tr_busy[k] = o_busy;
      tr_addr[k] = o_prog_addr;
      tr_op[k]   = o_operation_code;
      tr_mux[k]  = o_register_file_mux_addr;
      if (k == sw_idx) i_acumulator = sw_acc;
      if (k == start_idx) i_start = 1'b1;
      if (k == start_idx + 1) i_start = 1'b0;
      if (k == rst_idx) i_rst = 1'b1;
      if (k == rst_idx + 1) i_rst = 1'b0;
      tick();
    end
    i_start = 1'b0;
    i_rst   = 1'b0;
  endtask

  function automatic int count_acu(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (tr_acu[k]) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int k = 1; k <= n; k++) if (tr_done[k]) c++;
    return c;
  endfunction

  initial begin
    int busy_seen;
    int ce_seen;
    i_rst = 1'b1;
    i_start = 1'b0;
    i_acumulator = 8'd0;
    fill_rom(I_HALT);

    // reset values
    repeat (3) tick();
    check("rst_addr", o_prog_addr, 0);
    check("rst_op", o_operation_code, 0);
    check("rst_acu_ce", o_acumulator_ce, 0);
    check("rst_rf_ce", o_register_file_ce, 0);
    check("rst_mux", o_register_file_mux_addr, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);

    // idle without start
    i_rst = 1'b0;
    busy_seen = 0;
    ce_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_busy) busy_seen++;
      if (o_acumulator_ce || o_register_file_ce != 3'd0) ce_seen++;
    end
    check("idle_busy", busy_seen, 0);
    check("idle_ce", ce_seen, 0);

    // reset and start together: reset wins
    i_rst = 1'b1;
    i_start = 1'b1;
    tick();
    check("rst_start_busy", o_busy, 0);
    i_rst = 1'b0;
    i_start = 1'b0;
    tick();
    check("rst_start_idle", o_busy, 0);

    // EXEC, STORE, HALT
    fill_rom(I_HALT);
    rom[0] = {2'b00, OP_ADD, 4'd3, 6'd0};
    rom[1] = {2'b01, 11'd0, 3'd2};
    rom[2] = I_HALT;
    run_prog(16, -1, 8'd0, -1, -1);
    check("esh_busy1", tr_busy[1], 1);
    check("esh_addr1", tr_addr[1], 0);
    check("esh_acu_ce", tr_acu[4], 1);
    check("esh_op", tr_op[4], OP_ADD);
    check("esh_mux", tr_mux[4], 3);
    check("esh_acu_cnt", count_acu(16), 1);
    check("esh_rf_pre", tr_rf[7], 0);
    check("esh_rf_ce", tr_rf[8], 2);
    check("esh_rf_post", tr_rf[9], 0);
    check("esh_op_hold", tr_op[8], OP_ADD);
    check("esh_busy11", tr_busy[11], 1);
    check("esh_done", tr_done[12], 1);
    check("esh_busy12", tr_busy[12], 0);
    check("esh_busy13", tr_busy[13], 0);
    check("esh_done_cnt", count_done(16), 1);

    // JUMPZ taken
    fill_rom(I_HALT);
    rom[0] = {2'b10, 6'd0, 8'h10};
    i_acumulator = 8'd0;
    run_prog(10, -1, 8'd0, -1, -1);
    check("jz_taken_addr", tr_addr[5], 8'h10);
    check("jz_taken_done", tr_done[8], 1);

    // JUMPZ not taken
    i_acumulator = 8'd5;
    run_prog(10, -1, 8'd0, -1, -1);
    check("jz_not_addr", tr_addr[5], 8'h01);
    check("jz_not_done", tr_done[8], 1);

    // PC wrap 0xFF -> 0
    fill_rom(I_NOP);
    rom[0] = {2'b10, 6'd0, 8'hFF};
    rom[1] = I_HALT;
    i_acumulator = 8'd0;
    run_prog(18, 5, 8'd5, -1, -1);
    check("wrap_addr_ff", tr_addr[5], 8'hFF);
    check("wrap_addr_0", tr_addr[9], 8'h00);
    check("wrap_addr_1", tr_addr[13], 8'h01);
    check("wrap_done", tr_done[16], 1);
    check("wrap_busy", tr_busy[17], 0);

    // reset during DECODE of an EXEC instruction
    fill_rom(I_HALT);
    rom[0] = {2'b00, OP_SUB, 4'd5, 6'd0};
    i_acumulator = 8'd0;
    run_prog(10, -1, 8'd0, -1, 3);
    check("rmid_acu_ce", tr_acu[4], 0);
    check("rmid_busy", tr_busy[4], 0);
    check("rmid_op", tr_op[4], 0);
    check("rmid_mux", tr_mux[4], 0);
    check("rmid_addr", tr_addr[4], 0);
    check("rmid_acu_cnt", count_acu(10), 0);
    check("rmid_idle", tr_busy[8], 0);
    run_prog(10, -1, 8'd0, -1, -1);
    check("rmid_re_addr", tr_addr[1], 0);
    check("rmid_re_acu", tr_acu[4], 1);
    check("rmid_re_op", tr_op[4], OP_SUB);
    check("rmid_re_done", tr_done[8], 1);

    // start while busy is ignored
    fill_rom(I_HALT);
    rom[0] = {2'b00, OP_XOR, 4'd1, 6'd0};
    rom[1] = {2'b01, 11'd0, 3'd7};
    rom[2] = I_HALT;
    run_prog(16, -1, 8'd0, 5, -1);
    check("swb_acu", tr_acu[4], 1);
    check("swb_addr5", tr_addr[5], 1);
    check("swb_rf", tr_rf[8], 7);
    check("swb_addr9", tr_addr[9], 2);
    check("swb_done", tr_done[12], 1);
    check("swb_done_cnt", count_done(16), 1);
    check("swb_acu_cnt", count_acu(16), 1);
    check("swb_busy", tr_busy[13], 0);
    check("swb_busy_end", tr_busy[16], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program-driven control unit for the `alu` datapath. It fetches 16-bit instructions from a synchronous program ROM and decodes them. It then drives the ALU control inputs: operation code, accumulator clock-enable, register-file write enable and operand-mux address. It reads back the accumulator to resolve conditional jumps. It sits between the program memory and `alu`, and is the initiator side of the ALU control interface.

## Interface
- `PROG_AW`, 8: program address width; PC range 0..2^PROG_AW-1.
- `i_clk`  in  1  system clock, rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  level/pulse; sampled in IDLE only, starts execution at address 0.
- `o_prog_addr`  out  PROG_AW  program ROM address.
- `i_prog_data`  in  16  ROM read data, valid one cycle after `o_prog_addr`.
- `i_acumulator`  in  8  ALU accumulator value (`o_acumulator` of `alu`).
- `o_operation_code`  out  `operation` (pkg)  ALU operation.
- `o_acumulator_ce`  out  1  accumulator update enable.
- `o_register_file_ce`  out  3  register-file write select; 0 = no write, 1..7 = write register n.
- `o_register_file_mux_addr`  out  4  ALU operand-mux select.
- `o_busy`  out  1  high from leaving IDLE until return to IDLE.
- `o_done`  out  1  one-cycle pulse on HALT completion.

## Operation
- Instruction fields: [15:14] class, [13:10] op, [9:6] mux, [7:0] target, [2:0] reg.
- Class 00 EXEC:
  - `o_operation_code` = operation'([13:10]).
  - `o_register_file_mux_addr` = [9:6].
  - `o_acumulator_ce` = 1 for the EXEC cycle.
- Class 01 STORE: `o_register_file_ce` = [2:0] for the EXEC cycle. reg = 0 is a NOP.
- Class 10 JUMPZ: if `i_acumulator` == 8'd0 then PC ← [7:0] (truncated/zero-extended to PROG_AW), else PC+1.
- Class 11 HALT: `o_done` pulses, FSM returns to IDLE, PC ← 0.
- FSM states:
  - IDLE: `o_busy`=0; on `i_start` → FETCH, PC ← 0.
  - FETCH: `o_prog_addr` = PC → WAIT.
  - WAIT: ROM latency cycle → DECODE.
  - DECODE: IR ← `i_prog_data` → EXEC.
  - EXEC: perform action; PC updated; → FETCH (HALT → IDLE).
- `o_operation_code` and `o_register_file_mux_addr` are registered and hold their last EXEC-class values until the next EXEC-class instruction. Only the two CE outputs are pulses.
- PC wraps from 2^PROG_AW-1 to 0 without error.
- `i_start` outside IDLE is ignored.

## Timing
- All outputs registered; reset values:
  - `o_prog_addr`=0
  - `o_operation_code`=operation'(0)
  - `o_acumulator_ce`=0
  - `o_register_file_ce`=0
  - `o_register_file_mux_addr`=0
  - `o_busy`=0
  - `o_done`=0
  - state=IDLE, PC=0, IR=0.
- Instruction period: 4 cycles (FETCH, WAIT, DECODE, EXEC).
- `i_start` is sampled at edge N. FETCH is at N+1, and the first CE pulse is at N+4.
- `o_acumulator_ce` is high exactly one cycle per EXEC instruction. The accumulator updates at the edge ending that cycle.
- JUMPZ samples `i_acumulator` during its EXEC cycle. This is ≥3 cycles after any preceding CE pulse, so the result is always settled.
- `o_busy` rises the cycle after `i_start` is accepted. It falls in the same cycle `o_done` pulses.
- `i_rst` asserted in any state: next edge forces all reset values and aborts the instruction. Any CE pulse in progress is dropped.
- `i_rst` and `i_start` both high: reset wins.

## Test plan
- Reset and idle values:
  - Stimulus: hold `i_rst`=1 for 3 cycles.
  - Required: all outputs at reset values.
  - Stimulus: release `i_rst` with no `i_start` for 20 cycles.
  - Required: `o_busy`=0, no CE pulses.
- EXEC, STORE, HALT program:
  - ROM[0]=EXEC op=ADD mux=4'd3, ROM[1]=STORE reg=3'd2, ROM[2]=HALT.
  - Required: `o_acumulator_ce` pulse 4 cycles after start with opcode ADD and mux 3. Then `o_register_file_ce`=2 for one cycle 4 cycles later.
  - Required: `o_done` one cycle 4 cycles after that, then `o_busy`=0.
- JUMPZ taken vs. not taken:
  - ROM[0]=JUMPZ target 8'h10, with `i_acumulator`=0.
  - Required: next `o_prog_addr`=8'h10.
  - Repeat with `i_acumulator`=8'd5.
  - Required: next `o_prog_addr`=1.
- PC wrap:
  - Fill ROM with STORE reg=0 and put HALT at address 1 only. Jump to 8'hFF via JUMPZ with accumulator 0.
  - Required: after address 8'hFF, `o_prog_addr`=0, then 1, then HALT.
- Reset mid-op:
  - Assert `i_rst` in DECODE of an EXEC instruction.
  - Required: no `o_acumulator_ce` pulse, all outputs at reset values next cycle.
  - Required: a new `i_start` refetches address 0.
- Start while busy:
  - Pulse `i_start` during execution of a 3-instruction program.
  - Required: no PC restart, exact 12-cycle sequence, single `o_done`.
